// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter.
//   shift_mode_e : operation encodings carried on Mode
//   stage_shift  : one pipeline stage's transform (shift by 'amt' when 'en')
// Data is handled at MAX_W bits so one function serves every WIDTH; callers
// zero-extend their operand and keep the low WIDTH bits of the result.
package shifter_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRA = 3'b001,
    MODE_ROR = 3'b010,
    MODE_SRL = 3'b011,
    MODE_ROL = 3'b100
  } shift_mode_e;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode == MODE_SLL) || (mode == MODE_SRA) || (mode == MODE_ROR) ||
           (mode == MODE_SRL) || (mode == MODE_ROL);
  endfunction

  // Reserved modes force zero at every stage, so the result is zero no matter
  // which shift-amount bits are set.
  function automatic logic [MAX_W-1:0] stage_shift(
    input logic [MAX_W-1:0] data,
    input int               width,
    input int               amt,
    input logic             en,
    input logic [2:0]       mode
  );
    logic [MAX_W-1:0] res;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
    logic [IDX_W-1:0] msb;
    logic             sign;

    res  = '0;
    msb  = IDX_W'(width - 1);
    sign = data[msb];

    if (!mode_legal(mode)) return '0;
    if (!en) return data;

    for (int i = 0; i < MAX_W; i++) begin
      dst = IDX_W'(i);
      src = '0;
      if (i < width) begin
        case (mode)
          MODE_SLL: begin
            src      = IDX_W'(i - amt);
            res[dst] = (i >= amt) ? data[src] : 1'b0;
          end
          MODE_SRL: begin
            src      = IDX_W'(i + amt);
            res[dst] = (i + amt < width) ? data[src] : 1'b0;
          end
          MODE_SRA: begin
            src      = IDX_W'(i + amt);
            res[dst] = (i + amt < width) ? data[src] : sign;
          end
          MODE_ROR: begin
            src      = IDX_W'((i + amt) % width);
            res[dst] = data[src];
          end
          MODE_ROL: begin
            src      = IDX_W'((i + width - amt) % width);
            res[dst] = data[src];
          end
          default: res[dst] = 1'b0;
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One register stage of shifter_pipe. Shifts the incoming operand by
// 2**STAGE when shift-amount bit STAGE is set and registers the result
// together with valid, shift amount, mode and tag. Holds everything on stall.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   stall                hold all registers this cycle
//   in_valid/in_data/in_shamt/in_mode/in_tag   from previous stage (or pipe input)
//   valid/data/shamt/mode/tag                  registered stage contents
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int STAGE = 0,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shamt,
  output logic [2:0]         mode,
  output logic [TAG_W-1:0]   tag
);

  logic [MAX_W-1:0] wide_in;
  logic [MAX_W-1:0] wide_res;
  logic [WIDTH-1:0] shifted;

  assign wide_in  = MAX_W'(in_data);
  assign wide_res = stage_shift(wide_in, WIDTH, (1 << STAGE), in_shamt[STAGE], in_mode);
  assign shifted  = wide_res[WIDTH-1:0];

  generate
    if (WIDTH < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^wide_res[MAX_W-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      mode  <= '0;
      tag   <= '0;
    end else if (!stall) begin
      valid <= in_valid;
      data  <= shifted;
      shamt <= in_shamt;
      mode  <= in_mode;
      tag   <= in_tag;
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL/ROL) with valid/ready handshake.
// SHAMT_W stages, stage k applies shift-amount bit k. The whole pipe freezes
// when the last stage holds a result the consumer is not taking.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   In_Valid / In_Ready        input handshake
//   Shift_In, Shift_Val, Mode, Tag_In   operation
//   Out_Valid / Out_Ready      output handshake
//   Shift_Out, Tag_Out, Zero   result, its tag, result-is-zero flag
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [WIDTH-1:0]   Shift_In,
  input  logic [SHAMT_W-1:0] Shift_Val,
  input  logic [2:0]         Mode,
  input  logic [TAG_W-1:0]   Tag_In,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [WIDTH-1:0]   Shift_Out,
  output logic [TAG_W-1:0]   Tag_Out,
  output logic               Zero
);

  localparam int L = SHAMT_W;

  // Index 0 is the pipe input, index k+1 is the output of stage k.
  logic [L:0]              v;
  logic [L:0][WIDTH-1:0]   d;
  logic [L:0][SHAMT_W-1:0] s;
  logic [L:0][2:0]         m;
  logic [L:0][TAG_W-1:0]   t;
  logic                    stall;
  logic                    unused_tail;

  assign v[0] = In_Valid;
  assign d[0] = Shift_In;
  assign s[0] = Shift_Val;
  assign m[0] = Mode;
  assign t[0] = Tag_In;

  assign stall    = v[L] && !Out_Ready;
  assign In_Ready = !stall;

  generate
    for (genvar k = 0; k < L; k++) begin : g_stage
      shifter_stage #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .STAGE (k)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .in_valid (v[k]),
        .in_data  (d[k]),
        .in_shamt (s[k]),
        .in_mode  (m[k]),
        .in_tag   (t[k]),
        .valid    (v[k+1]),
        .data     (d[k+1]),
        .shamt    (s[k+1]),
        .mode     (m[k+1]),
        .tag      (t[k+1])
      );
    end
  endgenerate

  // The final stage's shift amount and mode have no consumer.
  assign unused_tail = ^{s[L], m[L]};

  assign Out_Valid = v[L];
  assign Shift_Out = d[L];
  assign Tag_Out   = t[L];
  assign Zero      = (d[L] == '0);

endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        In_Valid, In_Ready, Out_Valid, Out_Ready, Zero;
  logic [15:0] Shift_In, Shift_Out;
  logic [3:0]  Shift_Val;
  logic [2:0]  Mode;
  logic [3:0]  Tag_In, Tag_Out;

  logic        w_In_Valid, w_In_Ready, w_Out_Valid, w_Out_Ready, w_Zero;
  logic [31:0] w_Shift_In, w_Shift_Out;
  logic [4:0]  w_Shift_Val;
  logic [2:0]  w_Mode;
  logic [3:0]  w_Tag_In, w_Tag_Out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [15:0] d; logic [3:0] t; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode), .Tag_In(Tag_In),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Shift_Out(Shift_Out), .Tag_Out(Tag_Out), .Zero(Zero)
  );

  shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .In_Valid(w_In_Valid), .In_Ready(w_In_Ready),
    .Shift_In(w_Shift_In), .Shift_Val(w_Shift_Val), .Mode(w_Mode), .Tag_In(w_Tag_In),
    .Out_Valid(w_Out_Valid), .Out_Ready(w_Out_Ready),
    .Shift_Out(w_Shift_Out), .Tag_Out(w_Tag_Out), .Zero(w_Zero)
  );

  // Whole-operation reference, straight from the mode definitions.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int s, input logic [2:0] m);
    case (m)
      3'b000:  return x << s;
      3'b011:  return x >> s;
      3'b001:  return 16'($signed(x) >>> s);
      3'b010:  return (x >> s) | (x << (16 - s));
      3'b100:  return (x << s) | (x >> (16 - s));
      default: return 16'h0000;
    endcase
  endfunction

  task automatic drive(input logic vin, input logic [15:0] x, input logic [3:0] s,
                       input logic [2:0] m, input logic [3:0] tg, input logic ordy);
    In_Valid  = vin;
    Shift_In  = x;
    Shift_Val = s;
    Mode      = m;
    Tag_In    = tg;
    Out_Ready = ordy;
  endtask

  task automatic push_exp(input logic [15:0] x, input logic [3:0] s, input logic [2:0] m, input logic [3:0] tg);
    exp_t e;
    e.d = ref_shift(x, int'(s), m);
    e.t = tg;
    q.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", Out_Valid); end
    n_vec++; if (Shift_Out !== 16'h0000) begin n_err++; $display("FAIL reset_shift_out: got %h expected 0000", Shift_Out); end
    n_vec++; if (Tag_Out !== 4'h0) begin n_err++; $display("FAIL reset_tag_out: got %h expected 0", Tag_Out); end
    n_vec++; if (Zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", Zero); end
    n_vec++; if (In_Ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", In_Ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
  endtask

  task automatic test_sll_latency;
    int lat;
    @(negedge clk);
    drive(1'b1, 16'h00F1, 4'd4, 3'b000, 4'd3, 1'b1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
    #1;
    while (!Out_Valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk); #1;
    end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL sll_latency: got %0d expected 4", lat); end
    n_vec++; if (Shift_Out !== 16'h0F10) begin n_err++; $display("FAIL sll_data: got %h expected 0f10", Shift_Out); end
    n_vec++; if (Tag_Out !== 4'd3) begin n_err++; $display("FAIL sll_tag: got %h expected 3", Tag_Out); end
    n_vec++; if (Zero !== 1'b0) begin n_err++; $display("FAIL sll_zero: got %b expected 0", Zero); end
    @(negedge clk); #1;
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL sll_drained: got %b expected 0", Out_Valid); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bx[5]   = '{16'h8000, 16'h8000, 16'h0001, 16'h8001, 16'h00F1};
    logic [3:0]  bs[5]   = '{4'd15, 4'd15, 4'd1, 4'd1, 4'd4};
    logic [2:0]  bm[5]   = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b000};
    logic [15:0] bexp[5] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0003, 16'h0F10};
    int nout = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc < 5) drive(1'b1, bx[cyc], bs[cyc], bm[cyc], 4'(cyc + 1), 1'b1);
      else         drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
      #1;
      if (Out_Valid) begin
        n_vec++;
        if (nout >= 5) begin
          n_err++; $display("FAIL b2b_extra: got result %h, expected no result", Shift_Out);
        end else if (Shift_Out !== bexp[nout] || Tag_Out !== 4'(nout + 1) || cyc != nout + 4) begin
          n_err++;
          $display("FAIL b2b_result%0d: got data %h tag %h cycle %0d, expected data %h tag %h cycle %0d",
                   nout, Shift_Out, Tag_Out, cyc, bexp[nout], 4'(nout + 1), nout + 4);
        end
        nout++;
      end
    end
    n_vec++; if (nout !== 5) begin n_err++; $display("FAIL b2b_count: got %0d expected 5", nout); end
  endtask

  task automatic test_reserved;
    logic [15:0] rx[2]   = '{16'hFFFF, 16'h1234};
    logic [3:0]  rs[2]   = '{4'd5, 4'd0};
    logic [2:0]  rm[2]   = '{3'b111, 3'b000};
    logic [3:0]  rt[2]   = '{4'd10, 4'd11};
    logic [15:0] rexp[2] = '{16'h0000, 16'h1234};
    logic        rz[2]   = '{1'b1, 1'b0};
    int nout = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 2) drive(1'b1, rx[cyc], rs[cyc], rm[cyc], rt[cyc], 1'b1);
      else         drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
      #1;
      if (Out_Valid) begin
        n_vec++;
        if (nout >= 2) begin
          n_err++; $display("FAIL rsv_extra: got result %h, expected no result", Shift_Out);
        end else if (Shift_Out !== rexp[nout] || Zero !== rz[nout] || Tag_Out !== rt[nout] || cyc != nout + 4) begin
          n_err++;
          $display("FAIL rsv_result%0d: got data %h zero %b tag %h cycle %0d, expected data %h zero %b tag %h cycle %0d",
                   nout, Shift_Out, Zero, Tag_Out, cyc, rexp[nout], rz[nout], rt[nout], nout + 4);
        end
        nout++;
      end
    end
    n_vec++; if (nout !== 2) begin n_err++; $display("FAIL rsv_count: got %0d expected 2", nout); end
  endtask

  task automatic test_stall;
    logic [15:0] ox[6];
    logic [3:0]  os[6];
    logic [2:0]  om[6];
    int nacc = 0;
    int nout = 0;
    int idx;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      ox[i] = 16'($urandom);
      os[i] = 4'($urandom);
      om[i] = 3'($urandom_range(0, 4));
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      idx = (nacc < 6) ? nacc : 5;
      drive(nacc < 6, ox[idx], os[idx], om[idx], 4'(idx), 1'b0);
      #1;
      n_vec++;
      if (Out_Valid !== (cyc >= 4) || In_Ready !== (cyc < 4)) begin
        n_err++;
        $display("FAIL stall_handshake cyc%0d: got out_valid %b in_ready %b, expected %b %b",
                 cyc, Out_Valid, In_Ready, (cyc >= 4), (cyc < 4));
      end
      if (cyc >= 4 && q.size() > 0) begin
        n_vec++;
        if (Shift_Out !== q[0].d || Tag_Out !== q[0].t || Zero !== (q[0].d == 16'h0)) begin
          n_err++;
          $display("FAIL stall_hold cyc%0d: got %h tag %h zero %b, expected %h tag %h zero %b",
                   cyc, Shift_Out, Tag_Out, Zero, q[0].d, q[0].t, (q[0].d == 16'h0));
        end
      end
      if (In_Valid && In_Ready) begin push_exp(ox[idx], os[idx], om[idx], 4'(idx)); nacc++; end
    end
    n_vec++; if (nacc !== 4) begin n_err++; $display("FAIL stall_occupancy: got %0d expected 4", nacc); end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      idx = (nacc < 6) ? nacc : 5;
      drive(nacc < 6, ox[idx], os[idx], om[idx], 4'(idx), 1'b1);
      #1;
      if (Out_Valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stall_drain_extra: got %h, expected no result", Shift_Out);
        end else begin
          if (Shift_Out !== q[0].d || Tag_Out !== q[0].t) begin
            n_err++;
            $display("FAIL stall_drain%0d: got %h tag %h, expected %h tag %h", nout, Shift_Out, Tag_Out, q[0].d, q[0].t);
          end
          void'(q.pop_front());
        end
        nout++;
      end
      if (In_Valid && In_Ready) begin push_exp(ox[idx], os[idx], om[idx], 4'(idx)); nacc++; end
    end
    n_vec++; if (nout !== 6 || q.size() != 0) begin n_err++; $display("FAIL stall_total: got %0d out, %0d left, expected 6 out, 0 left", nout, q.size()); end
  endtask

  task automatic test_random;
    logic        vin, ordy, prev_stall;
    logic [15:0] x, prev_d;
    logic [3:0]  s, tg, prev_t;
    logic [2:0]  m;
    q.delete();
    prev_stall = 1'b0;
    prev_d = '0;
    prev_t = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      vin  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      x    = 16'($urandom);
      s    = 4'($urandom);
      m    = 3'($urandom_range(0, 7));
      tg   = 4'($urandom);
      drive(vin, x, s, m, tg, ordy);
      #1;
      n_vec++;
      if (In_Ready !== !(Out_Valid && !ordy)) begin
        n_err++; $display("FAIL rnd_in_ready cyc%0d: got %b expected %b", cyc, In_Ready, !(Out_Valid && !ordy));
      end
      if (prev_stall) begin
        n_vec++;
        if (Out_Valid !== 1'b1 || Shift_Out !== prev_d || Tag_Out !== prev_t) begin
          n_err++;
          $display("FAIL rnd_stable cyc%0d: got v %b %h tag %h, expected v 1 %h tag %h", cyc, Out_Valid, Shift_Out, Tag_Out, prev_d, prev_t);
        end
      end
      if (Out_Valid) begin
        n_vec++;
        if (Zero !== (Shift_Out == 16'h0)) begin
          n_err++; $display("FAIL rnd_zero cyc%0d: got %b expected %b", cyc, Zero, (Shift_Out == 16'h0));
        end
      end
      if (Out_Valid && ordy) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra cyc%0d: got %h, expected no result", cyc, Shift_Out);
        end else begin
          if (Shift_Out !== q[0].d || Tag_Out !== q[0].t) begin
            n_err++; $display("FAIL rnd_result cyc%0d: got %h tag %h, expected %h tag %h", cyc, Shift_Out, Tag_Out, q[0].d, q[0].t);
          end
          void'(q.pop_front());
        end
      end
      if (vin && In_Ready) push_exp(x, s, m, tg);
      n_vec++;
      if (q.size() > 4) begin n_err++; $display("FAIL rnd_capacity cyc%0d: got %0d in flight, expected at most 4", cyc, q.size()); end
      prev_stall = Out_Valid && !ordy;
      prev_d = Shift_Out;
      prev_t = Tag_Out;
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
      #1;
      if (Out_Valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_drain_extra: got %h, expected no result", Shift_Out);
        end else begin
          if (Shift_Out !== q[0].d || Tag_Out !== q[0].t) begin
            n_err++; $display("FAIL rnd_drain: got %h tag %h, expected %h tag %h", Shift_Out, Tag_Out, q[0].d, q[0].t);
          end
          void'(q.pop_front());
        end
      end
    end
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_lost: got %0d undelivered, expected 0", q.size()); end
  endtask

  task automatic test_reset_midflight;
    int lat;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc < 3) drive(1'b1, 16'h00FF << cyc, 4'd2, 3'b000, 4'(cyc + 4), 1'b1);
      else         drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b0);
    end
    @(negedge clk); #1;
    n_vec++; if (Out_Valid !== 1'b1 || In_Ready !== 1'b0) begin n_err++; $display("FAIL mid_prefill: got v %b rdy %b, expected 1 0", Out_Valid, In_Ready); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", Out_Valid); end
    n_vec++; if (Shift_Out !== 16'h0 || Tag_Out !== 4'h0 || Zero !== 1'b1) begin n_err++; $display("FAIL mid_rst_data: got %h tag %h zero %b, expected 0000 0 1", Shift_Out, Tag_Out, Zero); end
    n_vec++; if (In_Ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", In_Ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0003, 4'd1, 3'b000, 4'd9, 1'b1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
    #1;
    while (!Out_Valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk); #1;
    end
    n_vec++;
    if (lat !== 4 || Shift_Out !== 16'h0006 || Tag_Out !== 4'd9) begin
      n_err++; $display("FAIL mid_first_after: got lat %0d %h tag %h, expected lat 4 0006 tag 9", lat, Shift_Out, Tag_Out);
    end
    repeat (6) begin
      @(negedge clk); #1;
      n_vec++; if (Out_Valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got out_valid %b expected 0", Out_Valid); end
    end
  endtask

  task automatic test_w32;
    int lat;
    @(negedge clk);
    w_In_Valid = 1'b1; w_Shift_In = 32'h80000001; w_Shift_Val = 5'd31; w_Mode = 3'b010; w_Tag_In = 4'd5;
    w_Out_Ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    w_In_Valid = 1'b0;
    #1;
    while (!w_Out_Valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk); #1;
    end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL w32_latency: got %0d expected 5", lat); end
    n_vec++; if (w_Shift_Out !== 32'h00000003 || w_Tag_Out !== 4'd5 || w_Zero !== 1'b0) begin
      n_err++; $display("FAIL w32_ror: got %h tag %h zero %b, expected 00000003 tag 5 zero 0", w_Shift_Out, w_Tag_Out, w_Zero);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 3'b000, 4'h0, 1'b1);
    w_In_Valid = 1'b0; w_Shift_In = '0; w_Shift_Val = '0; w_Mode = '0; w_Tag_In = '0; w_Out_Ready = 1'b1;
    test_reset;
    test_sll_latency;
    test_back_to_back;
    test_reserved;
    test_stall;
    test_random;
    test_reset_midflight;
    test_w32;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
